// File: rtl/panel_scan_ctrl.sv
// panel_scan_ctrl: round-robin scanner for a daisy-chained 74HC595 panel with double-buffered slot data.
// Optional macro PANEL_BLANK_EN: drive oe_n high outside the HOLD dwell so shifting is never visible.
module panel_scan_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NDEV        = 2,
    parameter int unsigned HOLD_CYCLES = 64,
    localparam int unsigned SEL_W      = (NDEV > 1) ? $clog2(NDEV) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic [NDEV*WIDTH-1:0]   data_in_i,
    output logic                    ser_o,
    output logic                    shcp_o,
    output logic                    stcp_o,
    output logic                    oe_n_o,
    output logic [SEL_W-1:0]        dev_sel_o,
    output logic                    busy_o,
    output logic                    frame_done_o
);

    localparam int unsigned NW     = NDEV * WIDTH;
    localparam int unsigned BIT_W  = $clog2(NW + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH, ST_HOLD} state_e;

    state_e            state_q, state_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              phase_q, phase_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NW-1:0]     pend_q, pend_d;
    logic [NW-1:0]     act_q, act_d;
    logic [NW-1:0]     shreg_q, shreg_d;
    logic [SEL_W-1:0]  dev_sel_q, dev_sel_d;
    logic              ser_q, ser_d;
    logic              shcp_q, shcp_d;
    logic              stcp_q, stcp_d;
    logic              oe_n_q, oe_n_d;
    logic              busy_q, busy_d;
    logic              fd_q, fd_d;
`ifndef PANEL_BLANK_EN
    logic              shown_q, shown_d;
`endif
    logic              start_c;
    logic [SEL_W-1:0]  start_slot_c;
    logic [SEL_W-1:0]  slot_nxt_c;

    // Next-state and registered-output decode; outputs follow the state being entered.
    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        phase_d      = phase_q;
        hold_d       = hold_q;
        pend_d       = load_i ? data_in_i : pend_q;
        act_d        = act_q;
        shreg_d      = shreg_q;
        dev_sel_d    = dev_sel_q;
        start_c      = 1'b0;
        start_slot_c = dev_sel_q;
        slot_nxt_c   = (dev_sel_q == SEL_W'(NDEV - 1)) ? '0 : dev_sel_q + SEL_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (enable_i) start_c = 1'b1;
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (bit_q == BIT_W'(NW - 1)) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = {shreg_q[NW-2:0], 1'b0};
                    end
                end
            end
            ST_LATCH: begin
                state_d = ST_HOLD;
                hold_d  = HOLD_W'(HOLD_CYCLES - 1);
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    dev_sel_d    = slot_nxt_c;
                    start_slot_c = slot_nxt_c;
                    if (enable_i) start_c = 1'b1;
                    else          state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame boundary: promote pending data and build the one-hot-slot chain image.
        if (start_c) begin
            state_d = ST_SHIFT;
            bit_d   = '0;
            phase_d = 1'b0;
            act_d   = pend_d;
            for (int unsigned k = 0; k < NDEV; k++) begin
                shreg_d[k*WIDTH +: WIDTH] = (SEL_W'(k) == start_slot_c) ? act_d[k*WIDTH +: WIDTH] : '0;
            end
        end

        ser_d  = (state_d == ST_SHIFT) ? shreg_d[NW-1] : 1'b0;
        shcp_d = (state_d == ST_SHIFT) && phase_d;
        stcp_d = (state_d == ST_LATCH);
        busy_d = (state_d != ST_IDLE);
        fd_d   = (state_d == ST_HOLD) && (hold_d == '0);
`ifdef PANEL_BLANK_EN
        oe_n_d = (state_d != ST_HOLD);
`else
        shown_d = shown_q | stcp_d;
        oe_n_d  = !shown_d;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            hold_q    <= '0;
            pend_q    <= '0;
            act_q     <= '0;
            shreg_q   <= '0;
            dev_sel_q <= '0;
            ser_q     <= 1'b0;
            shcp_q    <= 1'b0;
            stcp_q    <= 1'b0;
            oe_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            fd_q      <= 1'b0;
`ifndef PANEL_BLANK_EN
            shown_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            act_q     <= act_d;
            shreg_q   <= shreg_d;
            dev_sel_q <= dev_sel_d;
            ser_q     <= ser_d;
            shcp_q    <= shcp_d;
            stcp_q    <= stcp_d;
            oe_n_q    <= oe_n_d;
            busy_q    <= busy_d;
            fd_q      <= fd_d;
`ifndef PANEL_BLANK_EN
            shown_q   <= shown_d;
`endif
        end
    end

    assign ser_o        = ser_q;
    assign shcp_o       = shcp_q;
    assign stcp_o       = stcp_q;
    assign oe_n_o       = oe_n_q;
    assign dev_sel_o    = dev_sel_q;
    assign busy_o       = busy_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Scoreboard bench for panel_scan_ctrl: stimulus predicts latched chain images and frame_done times,
// a monitor reconstructs the 595 chain from ser/shcp and checks each latch against the queue.
module tb_panel_scan_ctrl;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned NDEV        = 2;
    localparam int unsigned HOLD_CYCLES = 64;
    localparam int unsigned NW          = NDEV * WIDTH;
    localparam int unsigned SEL_W       = 1;
    localparam int          SLOT_CYC    = 2 * NW + 1 + HOLD_CYCLES;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              load;
    logic [NW-1:0]     data_in;
    logic              ser, shcp, stcp, oe_n, busy, frame_done;
    logic [SEL_W-1:0]  dev_sel;

    panel_scan_ctrl #(.WIDTH(WIDTH), .NDEV(NDEV), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .load_i(load), .data_in_i(data_in),
        .ser_o(ser), .shcp_o(shcp), .stcp_o(stcp), .oe_n_o(oe_n), .dev_sel_o(dev_sel),
        .busy_o(busy), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NW-1:0] frame;
        int            slot;
        int            at;
    } exp_t;

    exp_t lq[$];
    int   fdq[$];
    int   vectors = 0;
    int   errors  = 0;

    logic [WIDTH-1:0] m_pend [NDEV];
    int               m_slot = 0;

    function automatic void chk(input string name, input logic [NW-1:0] got, input logic [NW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Reference image: only the displayed slot carries its word, every other slot is zero.
    function automatic logic [NW-1:0] model_frame(input int s);
        logic [NW-1:0] f;
        f = NW'(m_pend[s]) << (s * WIDTH);
        return f;
    endfunction

    // Monitor: rebuild the chain on each shcp rise and compare at each stcp pulse.
    logic [NW-1:0] chain = '0;
    logic          shcp_p = 1'b0, ser_p = 1'b0, seen = 1'b0, in_hold = 1'b0;
    initial begin
        exp_t e;
        int   fd_at;
        logic exp_oe;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0; in_hold = 1'b0; shcp_p = 1'b0; ser_p = 1'b0;
            end else begin
                if (shcp && !shcp_p) begin
                    chk("ser_stable_at_shcp_rise", NW'(ser), NW'(ser_p));
                    chain = {chain[NW-2:0], ser};
                end
                if (stcp) begin
                    seen = 1'b1;
                    chk("shcp_low_at_latch", NW'(shcp), '0);
                    if (lq.size() == 0) begin
                        chk("unexpected_latch", NW'(1), NW'(0));
                    end else begin
                        e = lq.pop_front();
                        chk("latched_image", chain, e.frame);
                        chk("dev_sel_at_latch", NW'(dev_sel), NW'(e.slot));
                        chk("latch_cycle", NW'(cyc), NW'(e.at));
                    end
                end
                if (frame_done) begin
                    if (fdq.size() == 0) begin
                        chk("unexpected_frame_done", NW'(1), NW'(0));
                    end else begin
                        fd_at = fdq.pop_front();
                        chk("frame_done_cycle", NW'(cyc), NW'(fd_at));
                    end
                end
`ifdef PANEL_BLANK_EN
                exp_oe = !in_hold;
`else
                exp_oe = !seen;
`endif
                chk("oe_n", NW'(oe_n), NW'(exp_oe));
                if (stcp)       in_hold = 1'b1;
                if (frame_done) in_hold = 1'b0;
                shcp_p = shcp;
                ser_p  = ser;
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_load(input logic [NW-1:0] d);
        load    = 1'b1;
        data_in = d;
        for (int k = 0; k < NDEV; k++) m_pend[k] = d[k*WIDTH +: WIDTH];
        @(negedge clk);
        load    = 1'b0;
        data_in = {$urandom, $urandom};
    endtask

    // Run nf frames starting at the current negedge; enable drops during the last frame's shift.
    task automatic session(input int nf, input bit rnd);
        int s0, sf, slot, r;
        exp_t e;
        enable = 1'b1;
        s0 = cyc + 1;
        for (int f = 0; f < nf; f++) begin
            sf = s0 + f * SLOT_CYC;
            wait_cyc(sf - 1);
            if (rnd && ($urandom_range(0, 1) == 1)) do_load({$urandom, $urandom});
            slot    = (m_slot + f) % NDEV;
            e.frame = model_frame(slot);
            e.slot  = slot;
            e.at    = sf + 2 * NW;
            lq.push_back(e);
            fdq.push_back(sf + SLOT_CYC - 1);
            wait_cyc(sf);
            if (f == 0) chk("busy_at_start", NW'(busy), NW'(1));
            if (f == nf - 1) begin
                r = rnd ? int'($urandom_range(1, 2 * NW - 1)) : 10;
                wait_cyc(sf + r);
                enable = 1'b0;
            end else if (rnd && ($urandom_range(0, 1) == 1)) begin
                r = int'($urandom_range(1, SLOT_CYC - 2));
                wait_cyc(sf + r);
                do_load({$urandom, $urandom});
            end
        end
        wait_cyc(s0 + nf * SLOT_CYC);
        chk("busy_low_after_run", NW'(busy), '0);
        chk("stcp_low_in_idle", NW'(stcp), '0);
        chk("dev_sel_after_run", NW'(dev_sel), NW'((m_slot + nf) % NDEV));
        repeat (5) @(negedge clk);
        chk("shcp_static_in_idle", NW'(shcp), '0);
        chk("latch_queue_drained", NW'(lq.size()), '0);
        chk("frame_done_queue_drained", NW'(fdq.size()), '0);
        m_slot = (m_slot + nf) % NDEV;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ser"}, NW'(ser), '0);
        chk({tag, "_shcp"}, NW'(shcp), '0);
        chk({tag, "_stcp"}, NW'(stcp), '0);
        chk({tag, "_oe_n"}, NW'(oe_n), NW'(1));
        chk({tag, "_dev_sel"}, NW'(dev_sel), '0);
        chk({tag, "_busy"}, NW'(busy), '0);
        chk({tag, "_frame_done"}, NW'(frame_done), '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        data_in = '0;
        for (int k = 0; k < NDEV; k++) m_pend[k] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_load({32'h0000_0009, 32'h0000_000B});
        repeat (3) @(negedge clk);
        session(2, 1'b0);
        session(4, 1'b0);
        session(1, 1'b0);

        // Asynchronous reset in the middle of a shift, from a non-zero slot.
        enable = 1'b1;
        repeat (20) @(negedge clk);
        chk("busy_before_reset", NW'(busy), NW'(1));
        chk("dev_sel_before_reset", NW'(dev_sel), NW'(1));
        #2 rst_n = 1'b0;
        enable = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NDEV; k++) m_pend[k] = '0;
        m_slot = 0;
        repeat (2) @(negedge clk);
        session(3, 1'b0);

        session(5, 1'b1);
        session(6, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/panel_scan_ctrl.md
# panel_scan_ctrl

Frame scheduler driving a daisy-chained 74HC595 LED panel from one system clock. Latches one data word per device, then round-robins: for each active slot it serially shifts a full chain frame (active device's word, every other device zero), pulses the storage latch and holds the image for a fixed dwell. Sits between the data/register interface and the panel connector (SER/SHCP/STCP/OE).

## Interface
- `WIDTH`, 32: bits per device (four 595s per device).
- `NDEV`, 2: devices in the chain; slot 0 is nearest SER.
- `HOLD_CYCLES`, 64: dwell cycles per slot after latch; legal range ≥1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run scan while high.
- `load`  in  1  single-cycle pulse; capture `data_in` into the pending buffer.
- `data_in`  in  NDEV*WIDTH  slot k at bits [k*WIDTH +: WIDTH].
- `ser`  out  1  serial data to chain.
- `shcp`  out  1  shift clock.
- `stcp`  out  1  storage latch clock.
- `oe_n`  out  1  output enable, active-low.
- `dev_sel`  out  $clog2(NDEV)  slot currently displayed/being shifted.
- `busy`  out  1  FSM not in IDLE.
- `frame_done`  out  1  one-cycle pulse at end of each slot's HOLD.

## Operation
- Double buffer: `load` writes pending buffer; pending copied to active buffer only at a frame boundary (entering SHIFT). Load while IDLE takes effect on next SHIFT entry.
- Frame word for slot s: {slot NDEV-1 … slot 0}, slot k = active[k] if k==s else 0; shifted MSB first (NDEV*WIDTH bits).
- FSM: IDLE → SHIFT (when `enable`) → LATCH → HOLD → SHIFT of slot (s+1) mod NDEV if `enable`, else IDLE.
- IDLE: `shcp`=`stcp`=0, `ser`=0, `dev_sel` held; image stays as last latched.
- SHIFT: bit counter 0…NDEV*WIDTH-1; each bit occupies two cycles: phase 0 `shcp`=0 with `ser` updated; phase 1 `shcp`=1, `ser` stable.
- LATCH: one cycle `stcp`=1, `shcp`=0.
- HOLD: counter HOLD_CYCLES-1 down to 0; `frame_done` high on final HOLD cycle; `dev_sel` advances (mod NDEV, wrap NDEV-1→0) on the transition out of HOLD.
- `enable` deasserted mid-frame: current slot completes through HOLD, then IDLE. Reasserted in IDLE: resume at next slot.
- `load` coincident with SHIFT entry: new data is used for that frame.
- Reset (any state, asynchronous): `ser`=0, `shcp`=0, `stcp`=0, `oe_n`=1, `dev_sel`=0, `busy`=0, `frame_done`=0, buffers and counters cleared, state IDLE.
- `oe_n`: 1 from reset until first LATCH; 0 from the first LATCH cycle onward (see Configuration).

## Timing
- All outputs registered; no combinational input-to-output paths.
- `enable` sampled high in IDLE → SHIFT next cycle, `busy` high same cycle.
- Per slot: 2·NDEV·WIDTH shift cycles + 1 latch + HOLD_CYCLES. Defaults: 128 + 1 + 64 = 193 cycles.
- `ser` changes only in phase 0 (shcp low); setup ≥1 clk before shcp rise, hold ≥1 clk after.
- `stcp` rises exactly one cycle after last `shcp` rise.

## Configuration
- `PANEL_BLANK_EN` defined: `oe_n`=1 throughout SHIFT and LATCH, 0 only during HOLD (blanking, no ghosting during shift).
- Undefined: `oe_n` stays 0 continuously after first LATCH; chain shifts while visible.

## Test plan
- Reset mid-SHIFT (rst low 3 cycles) → all outputs at reset values within same cycle, `busy`=0, next start at slot 0.
- data_in slot0=0x0000000B, slot1=0x00000009, load, enable → after 129 cycles latched chain = {0x00000000, 0x0000000B}, `dev_sel`=0; after next 193 cycles chain = {0x00000009, 0x00000000}, `dev_sel`=1.
- Continuous run, 4 slots → `dev_sel` 0,1,0,1; `frame_done` pulses every 193 cycles, exactly one cycle wide.
- `load` of slot0=0xFFFFFFFF during HOLD of slot 0 → current image unchanged; next slot-0 frame shows 0xFFFFFFFF.
- `enable` dropped in SHIFT → frame finishes (latch + 64 hold), then IDLE, `busy`=0, `shcp` static 0.
- With `PANEL_BLANK_EN`: `oe_n`=1 for all 129 shift/latch cycles, 0 for the 64 HOLD cycles; without: `oe_n`=0 throughout after first latch.
